// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } lsu_state_t;

  // Reserved size 2'b11 behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    byte_en = 4'b0001 << lane;
      SZ_H:    byte_en = 4'b0011 << lane;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data bus between the load/store unit (master) and the memory slave.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] DataAddr;
  logic [31:0]       WriteData;
  logic [3:0]        ByteEn;
  logic              BusValid;
  logic              BusWrite;
  logic              BusReady;
  logic [31:0]       BusRData;

  modport master (
    output DataAddr, WriteData, ByteEn, BusValid, BusWrite,
    input  BusReady, BusRData
  );

  modport slave (
    input  DataAddr, WriteData, ByteEn, BusValid, BusWrite,
    output BusReady, BusRData
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane handling: load lane select with sign/zero extension,
// store data lane replication.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_raw,
  output logic [31:0] st_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (ld_lane)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];

    case (ld_size)
      SZ_B:    ld_data = ld_sext ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      SZ_H:    ld_data = ld_sext ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_data = ld_raw;
    endcase

    case (st_size)
      SZ_B:    st_data = {4{st_raw[7:0]}};
      SZ_H:    st_data = {2{st_raw[15:0]}};
      default: st_data = st_raw;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: memory-stage access to valid/ready bus transaction.
// Optional one-entry store buffer: MEM_LSU_STORE_BUF_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  SizeM,
  input  logic        UnsignedM,
  output logic        StallMem,
  output logic        MisalignM,
  output logic [31:0] ReadDataW,
  mem_lsu_if.master   bus
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              sext_q, sext_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef MEM_LSU_STORE_BUF_EN
  logic              buf_q, buf_d;
`endif

  logic        req;
  logic        mis;
  logic        stall;
  logic        misalign;
  logic [31:0] ld_fmt;
  logic [31:0] st_rep;

  mem_lsu_align u_align (
    .ld_size (size_q),
    .ld_lane (lane_q),
    .ld_sext (sext_q),
    .ld_raw  (bus.BusRData),
    .ld_data (ld_fmt),
    .st_size (SizeM),
    .st_raw  (WriteDataM),
    .st_data (st_rep)
  );

  always_comb begin
    req      = (MemReadM | MemWriteM) & ~rst;
    mis      = req & is_misaligned(SizeM, ALUResultM[1:0]);
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    valid_d  = valid_q;
    write_d  = write_q;
    size_d   = size_q;
    lane_d   = lane_q;
    sext_d   = sext_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    misalign = 1'b0;
`ifdef MEM_LSU_STORE_BUF_EN
    buf_d    = buf_q;
`endif

    case (state_q)
      IDLE: begin
        if (mis) begin
          misalign = 1'b1;
          rdata_d  = '0;
        end else if (req) begin
          state_d = BUS;
          valid_d = 1'b1;
          write_d = MemWriteM;
          addr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
          wdata_d = st_rep;
          be_d    = byte_en(SizeM, ALUResultM[1:0]);
          size_d  = SizeM;
          lane_d  = ALUResultM[1:0];
          sext_d  = ~(UnsignedM | arm);
          stall   = 1'b1;
`ifdef MEM_LSU_STORE_BUF_EN
          // Stores retire into the buffer so the pipeline keeps moving.
          if (MemWriteM) begin
            buf_d = 1'b1;
            stall = 1'b0;
          end
`endif
        end
      end

      BUS: begin
        stall = ~bus.BusReady;
`ifdef MEM_LSU_STORE_BUF_EN
        // A follow-on op must wait until it can be seen again in IDLE.
        if (buf_q) stall = req;
`endif
        if (bus.BusReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          if (!write_q) rdata_d = ld_fmt;
`ifdef MEM_LSU_STORE_BUF_EN
          buf_d = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= SZ_B;
      lane_q  <= '0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_LSU_STORE_BUF_EN
      buf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      write_q <= write_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
`ifdef MEM_LSU_STORE_BUF_EN
      buf_q   <= buf_d;
`endif
    end
  end

  assign StallMem      = stall & ~rst;
  assign MisalignM     = misalign;
  assign ReadDataW     = rdata_q;
  assign bus.DataAddr  = addr_q;
  assign bus.WriteData = wdata_q;
  assign bus.ByteEn    = be_q;
  assign bus.BusValid  = valid_q;
  assign bus.BusWrite  = write_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalignment, reset in BUS.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst, arm, MemReadM, MemWriteM, UnsignedM;
  logic        StallMem, MisalignM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataW;
  logic [1:0]  SizeM;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32)) bus_if ();

  mem_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .SizeM      (SizeM),
    .UnsignedM  (UnsignedM),
    .StallMem   (StallMem),
    .MisalignM  (MisalignM),
    .ReadDataW  (ReadDataW),
    .bus        (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input logic uns, input logic am);
    MemReadM   = rd;
    MemWriteM  = wr;
    ALUResultM = a;
    WriteDataM = d;
    SizeM      = sz;
    UnsignedM  = uns;
    arm        = am;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);
  endtask

  // Zero-wait load: issue, complete, then check W-stage data.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic am, input logic [31:0] rdata,
                         input logic [3:0] be, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    step();
    drive(1'b1, 1'b0, a, 32'h0, sz, uns, am);
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("ld_issue_stall", StallMem, 1);
    chk("ld_issue_valid", bus_if.BusValid, 0);
    step();
    bus_if.BusReady = 1'b1;
    bus_if.BusRData = rdata;
    @(negedge clk);
    chk("ld_valid", bus_if.BusValid, 1);
    chk("ld_byteen", bus_if.ByteEn, be);
    chk("ld_addr", bus_if.DataAddr, exp_addr);
    chk("ld_write", bus_if.BusWrite, 0);
    chk("ld_done_stall", StallMem, 0);
    step();
    idle();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("ld_rdata", ReadDataW, exp);
    chk("ld_valid_clr", bus_if.BusValid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1'b0);
    bus_if.BusReady = 1'b0;
    bus_if.BusRData = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall", StallMem, 0);
    chk("rst_misalign", MisalignM, 0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_valid", bus_if.BusValid, 0);
    chk("rst_write", bus_if.BusWrite, 0);
    chk("rst_byteen", bus_if.ByteEn, 0);
    chk("rst_addr", bus_if.DataAddr, 0);
    chk("rst_wdata", bus_if.WriteData, 0);
    chk("rst_rdata", ReadDataW, 0);

    do_load(32'h100, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h100, 32'hDEADBEEF);
    do_load(32'h103, 2'b00, 1'b0, 1'b0, 32'h80123456, 4'b1000, 32'h100, 32'hFFFFFF80);
    do_load(32'h103, 2'b00, 1'b0, 1'b1, 32'h80123456, 4'b1000, 32'h100, 32'h00000080);
    do_load(32'h002, 2'b01, 1'b0, 1'b0, 32'h80011234, 4'b1100, 32'h000, 32'hFFFF8001);
    do_load(32'h101, 2'b00, 1'b1, 1'b0, 32'h0000F000, 4'b0010, 32'h100, 32'h000000F0);
    do_load(32'h000, 2'b01, 1'b0, 1'b1, 32'h12348765, 4'b0011, 32'h000, 32'h00008765);
    do_load(32'h108, 2'b11, 1'b0, 1'b0, 32'h13579BDF, 4'b1111, 32'h108, 32'h13579BDF);
    do_load(32'h000, 2'b01, 1'b0, 1'b1, 32'h12348765, 4'b0011, 32'h000, 32'h00008765);
    step();
    step();
    @(negedge clk);
    chk("rdata_hold", ReadDataW, 32'h00008765);

`ifdef MEM_LSU_STORE_BUF_EN
    // Buffered store, then a load that must wait for the drain.
    step();
    drive(1'b0, 1'b1, 32'h300, 32'h11223344, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb_st_stall", StallMem, 0);
    step();
    drive(1'b1, 1'b0, 32'h304, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb_ld_wait0", StallMem, 1);
    chk("sb_st_write", bus_if.BusWrite, 1);
    chk("sb_st_addr", bus_if.DataAddr, 32'h300);
    chk("sb_st_wdata", bus_if.WriteData, 32'h11223344);
    step();
    @(negedge clk);
    chk("sb_ld_wait1", StallMem, 1);
    step();
    bus_if.BusReady = 1'b1;
    @(negedge clk);
    chk("sb_ld_wait_drain", StallMem, 1);
    step();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("sb_ld_issue_stall", StallMem, 1);
    chk("sb_ld_issue_valid", bus_if.BusValid, 0);
    step();
    bus_if.BusReady = 1'b1;
    bus_if.BusRData = 32'hCAFEF00D;
    @(negedge clk);
    chk("sb_ld_write", bus_if.BusWrite, 0);
    chk("sb_ld_addr", bus_if.DataAddr, 32'h304);
    chk("sb_ld_done_stall", StallMem, 0);
    step();
    idle();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("sb_ld_rdata", ReadDataW, 32'hCAFEF00D);
`else
    // Half store held for three wait cycles.
    step();
    drive(1'b0, 1'b1, 32'h202, 32'hABCD1234, 2'b01, 1'b0, 1'b0);
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    cnt = (StallMem === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      if (StallMem === 1'b1) cnt++;
      chk("st_valid", bus_if.BusValid, 1);
      chk("st_write", bus_if.BusWrite, 1);
      chk("st_addr", bus_if.DataAddr, 32'h200);
      chk("st_byteen", bus_if.ByteEn, 4'b1100);
      chk("st_wdata", bus_if.WriteData, 32'h12341234);
    end
    step();
    bus_if.BusReady = 1'b1;
    @(negedge clk);
    if (StallMem === 1'b1) cnt++;
    chk("st_stall_cycles", cnt, 4);
    step();
    idle();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("st_valid_clr", bus_if.BusValid, 0);
    chk("st_rdata_hold", ReadDataW, 32'h00008765);

    step();
    drive(1'b0, 1'b1, 32'h001, 32'h000000A5, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("stb_stall", StallMem, 1);
    step();
    bus_if.BusReady = 1'b1;
    @(negedge clk);
    chk("stb_byteen", bus_if.ByteEn, 4'b0010);
    chk("stb_wdata", bus_if.WriteData, 32'hA5A5A5A5);
    chk("stb_addr", bus_if.DataAddr, 32'h000);
    step();
    idle();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
`endif

    // Misaligned word load and half store.
    step();
    drive(1'b1, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_ld_pulse", MisalignM, 1);
    chk("mis_ld_stall", StallMem, 0);
    step();
    drive(1'b0, 1'b1, 32'h203, 32'h0000FFFF, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_ld_valid", bus_if.BusValid, 0);
    chk("mis_ld_rdata", ReadDataW, 0);
    chk("mis_st_pulse", MisalignM, 1);
    chk("mis_st_stall", StallMem, 0);
    step();
    idle();
    @(negedge clk);
    chk("mis_st_valid", bus_if.BusValid, 0);
    chk("mis_clr", MisalignM, 0);

    // Back-to-back loads.
    step();
    drive(1'b1, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_issue0", StallMem, 1);
    step();
    bus_if.BusReady = 1'b1;
    bus_if.BusRData = 32'h11111111;
    @(negedge clk);
    chk("b2b_done0", StallMem, 0);
    step();
    drive(1'b1, 1'b0, 32'h014, 32'h0, 2'b10, 1'b0, 1'b0);
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("b2b_issue1", StallMem, 1);
    chk("b2b_rdata0", ReadDataW, 32'h11111111);
    chk("b2b_valid_gap", bus_if.BusValid, 0);
    step();
    bus_if.BusReady = 1'b1;
    bus_if.BusRData = 32'h22222222;
    @(negedge clk);
    chk("b2b_addr1", bus_if.DataAddr, 32'h014);
    chk("b2b_valid1", bus_if.BusValid, 1);
    step();
    idle();
    bus_if.BusReady = 1'b0;
    @(negedge clk);
    chk("b2b_rdata1", ReadDataW, 32'h22222222);

    // Reset while waiting in BUS.
    step();
    drive(1'b1, 1'b0, 32'h040, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rb_valid", bus_if.BusValid, 1);
    chk("rb_stall", StallMem, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rb_rst_stall", StallMem, 0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rb_valid_drop", bus_if.BusValid, 0);
    chk("rb_stall_after", StallMem, 0);
    chk("rb_rdata", ReadDataW, 0);
    do_load(32'h044, 2'b10, 1'b0, 1'b0, 32'h00000005, 4'b1111, 32'h044, 32'h00000005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
